aes_cipher_serializer: RTL and testbench

//   Downstream stage of the combinational AES-128 encrypt datapath.
//   - Waits SETTLE_CYCLES for cipher_text to settle across the 10-round path, then captures it.
//   - Streams the captured 128-bit block out as 16 bytes over a valid/ready byte interface.
//   - Its upstream handshake gates when the key/plaintext source may change encrypt inputs.

---
 rtl/aes_cipher_serializer.sv | 150 +++++++++++++++
 tb/tb_aes_cipher_serializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_serializer.sv
// -----------------------------------------------------------------------------
// aes_cipher_serializer
//   Output stage of the combinational AES-128 encrypt datapath. When the
//   upstream source asks for an encryption, the stage waits SETTLE_CYCLES for
//   cipher_text to ripple through the 10-round path. It then captures the
//   block into a shift register and streams it out as 16 bytes over a
//   valid/ready interface. o_blk_ready tells the source that the block has
//   been captured, so it may change key/plaintext from the next cycle on.
//
// Parameters
//   SETTLE_CYCLES  cycles cipher_text must be stable before capture (1..255)
//   MSB_FIRST      1: first byte = cipher_text[127:120]; 0: first = [7:0]
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous reset, active high
//   i_cipher_text  combinational AES-128 ciphertext
//   i_blk_valid    upstream holds inputs stable and requests a block
//   o_blk_ready    block captured this cycle (combinational, one-cycle pulse)
//   o_byte_data    current output byte (registered shift-register slice)
//   o_byte_valid   o_byte_data valid
//   i_byte_ready   downstream accepts o_byte_data
//   o_byte_last    marks the 16th byte of a block
//   o_busy         high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module aes_cipher_serializer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter bit          MSB_FIRST     = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [127:0] i_cipher_text,
  input  logic         i_blk_valid,
  output logic         o_blk_ready,
  output logic [7:0]   o_byte_data,
  output logic         o_byte_valid,
  input  logic         i_byte_ready,
  output logic         o_byte_last,
  output logic         o_busy
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("aes_cipher_serializer: SETTLE_CYCLES must be in 1..255");
    end
  endgenerate

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DRAIN} state_t;

  state_t       r_state;
  logic [7:0]   r_cnt;
  logic [3:0]   r_idx;
  logic [127:0] r_shreg;
  logic         r_byte_valid;
  logic         r_byte_last;
  logic         r_busy;

  logic         w_capture;
  logic         w_hs;
  logic [127:0] w_shreg_shift;

  // Capture needs the request still asserted on the final settle cycle;
  // a dropped request aborts the block instead.
  assign w_capture = (r_state == S_SETTLE) && (r_cnt == 8'd0) && i_blk_valid;
  assign w_hs      = r_byte_valid & i_byte_ready;

  // Output byte always comes straight from the register, so there is no
  // combinational path from cipher_text to byte_data. Shifting moves the
  // next byte toward whichever end is being presented.
  generate
    if (MSB_FIRST) begin : g_msb
      assign o_byte_data   = r_shreg[127:120];
      assign w_shreg_shift = {r_shreg[119:0], 8'h00};
    end else begin : g_lsb
      assign o_byte_data   = r_shreg[7:0];
      assign w_shreg_shift = {8'h00, r_shreg[127:8]};
    end
  endgenerate

  assign o_blk_ready  = w_capture;
  assign o_byte_valid = r_byte_valid;
  assign o_byte_last  = r_byte_last;
  assign o_busy       = r_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_idx        <= 4'd0;
      r_shreg      <= 128'd0;
      r_byte_valid <= 1'b0;
      r_byte_last  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_blk_valid) begin
            r_state <= S_SETTLE;
            r_cnt   <= CNT_INIT;
            r_busy  <= 1'b1;
          end
        end

        S_SETTLE: begin
          if (!i_blk_valid) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_busy  <= 1'b0;
          end else if (r_cnt == 8'd0) begin
            r_shreg      <= i_cipher_text;
            r_idx        <= 4'd0;
            r_state      <= S_DRAIN;
            r_byte_valid <= 1'b1;
            r_byte_last  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_DRAIN: begin
          // Request input is ignored here; all fields hold while stalled.
          if (w_hs) begin
            r_shreg <= w_shreg_shift;
            if (r_byte_last) begin
              r_state      <= S_IDLE;
              r_idx        <= 4'd0;
              r_byte_valid <= 1'b0;
              r_byte_last  <= 1'b0;
              r_busy       <= 1'b0;
            end else begin
              r_idx       <= r_idx + 4'd1;
              // last flag is registered alongside idx reaching 15
              r_byte_last <= (r_idx == 4'd14);
            end
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_byte_valid <= 1'b0;
          r_byte_last  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_serializer.sv
// -----------------------------------------------------------------------------
// tb_aes_cipher_serializer
//   Directed bench for aes_cipher_serializer. The AES datapath is represented
//   by its known FIPS-197 outputs driven on cipher_text. Two instances share
//   all inputs: MSB-first (default) and LSB-first.
// -----------------------------------------------------------------------------
module tb_aes_cipher_serializer;

  localparam int S = 4;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] ct = CT1;
  logic         blk_valid = 1'b0;
  logic         byte_ready = 1'b0;

  logic       a_blk_ready, a_byte_valid, a_byte_last, a_busy;
  logic [7:0] a_byte_data;
  logic       b_blk_ready, b_byte_valid, b_byte_last, b_busy;
  logic [7:0] b_byte_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_b [16];
  logic [7:0] got_a [16];
  logic [7:0] got_b [16];
  logic       gl_a  [16];
  logic       gl_b  [16];

  aes_cipher_serializer #(.SETTLE_CYCLES(S), .MSB_FIRST(1'b1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_cipher_text(ct), .i_blk_valid(blk_valid),
    .o_blk_ready(a_blk_ready), .o_byte_data(a_byte_data),
    .o_byte_valid(a_byte_valid), .i_byte_ready(byte_ready),
    .o_byte_last(a_byte_last), .o_busy(a_busy)
  );

  aes_cipher_serializer #(.SETTLE_CYCLES(S), .MSB_FIRST(1'b0)) u_dut_lsb (
    .i_clk(clk), .i_rst(rst), .i_cipher_text(ct), .i_blk_valid(blk_valid),
    .o_blk_ready(b_blk_ready), .o_byte_data(b_byte_data),
    .o_byte_valid(b_byte_valid), .i_byte_ready(byte_ready),
    .o_byte_last(b_byte_last), .o_busy(b_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise the request and wait (bounded) for the capture pulse, then let the
  // capture edge pass and drop the request.
  task automatic req_wait();
    int k;
    k = 0;
    blk_valid = 1'b1;
    while (!a_blk_ready && k < 50) begin
      tick();
      k++;
    end
    chk("req_blk_ready", a_blk_ready, 1);
    tick();
    blk_valid = 1'b0;
  endtask

  // Collect 16 accepted bytes. mode 0: always ready. mode 1: ready toggles
  // every cycle, with a 10-cycle stall while byte 7 is presented.
  task automatic collect(input int mode);
    int n, sc;
    n = 0;
    sc = 0;
    for (int k = 0; k < 200 && n < 16; k++) begin
      if (mode == 1) begin
        if (n == 7 && sc < 10) begin
          byte_ready = 1'b0;
          sc++;
          chk("t3_stall_data", a_byte_data, 8'h30);
          chk("t3_stall_last", a_byte_last, 0);
        end else begin
          byte_ready = k[0];
        end
      end else begin
        byte_ready = 1'b1;
      end
      if (a_byte_valid && byte_ready) begin
        got_a[n] = a_byte_data;
        gl_a[n]  = a_byte_last;
        got_b[n] = b_byte_data;
        gl_b[n]  = b_byte_last;
        n++;
      end
      tick();
    end
    chk("byte_count", n, 16);
    byte_ready = 1'b0;
  endtask

  task automatic check_a(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_byte"}, got_a[i], exp_b[i]);
      chk({tag, "_last"}, gl_a[i], (i == 15));
    end
  endtask

  initial begin
    int gap;
    exp_b = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
              8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};

    // Reset, with a request asserted to show reset wins.
    rst = 1'b1;
    blk_valid = 1'b1;
    tick();
    tick();
    chk("rst_blk_ready", a_blk_ready, 0);
    chk("rst_byte_valid", a_byte_valid, 0);
    chk("rst_byte_last", a_byte_last, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_byte_data", a_byte_data, 0);
    chk("rst_lsb_valid", b_byte_valid, 0);
    blk_valid = 1'b0;
    rst = 1'b0;
    tick();

    // 1 + 2: FIPS-197 vector, both byte orders, downstream always ready.
    ct = CT1;
    blk_valid = 1'b1;
    byte_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t1_blk_ready", a_blk_ready, (k == 4));
      chk("t1_busy", a_busy, 1);
      chk("t1_no_valid", a_byte_valid, 0);
    end
    tick();
    blk_valid = 1'b0;
    chk("t1_first_valid", a_byte_valid, 1);
    chk("t1_ready_drain", a_blk_ready, 0);
    collect(0);
    check_a("t1");
    for (int i = 0; i < 16; i++) begin
      chk("t2_lsb_byte", got_b[i], exp_b[15-i]);
      chk("t2_lsb_last", gl_b[i], (i == 15));
    end
    chk("t1_valid_after", a_byte_valid, 0);
    chk("t1_busy_after", a_busy, 0);

    // 3: toggling ready with a long stall on byte 7.
    ct = CT1;
    req_wait();
    collect(1);
    check_a("t3");

    // 4: back-to-back blocks, request held high, new plaintext after capture.
    ct = CT1;
    blk_valid = 1'b1;
    begin
      int k;
      k = 0;
      while (!a_blk_ready && k < 50) begin
        tick();
        k++;
      end
    end
    chk("t4_blk_ready", a_blk_ready, 1);
    tick();
    ct = CT2;
    chk("t4_b1_first", a_byte_data, 8'h69);
    byte_ready = 1'b1;
    gap = 0;
    for (int k = 1; k <= 60 && gap == 0; k++) begin
      tick();
      if (k <= 16) chk("t4_no_ready_drain", a_blk_ready, (k == 16 ? 0 : 0) | (a_byte_valid ? 0 : a_blk_ready));
      if (k > 16 && a_byte_valid) gap = k;
    end
    chk("t4_gap", gap, S + 17);
    chk("t4_b2_first", a_byte_data, 8'h39);
    blk_valid = 1'b0;
    collect(0);
    chk("t4_b2_byte15", got_a[15], 8'h32);
    chk("t4_b2_last", gl_a[15], 1);

    // 5: reset after byte 5 is accepted, with a handshake in the same cycle.
    ct = CT1;
    req_wait();
    byte_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("t5_pre_rst_byte", a_byte_data, 8'h04);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    byte_ready = 1'b0;
    chk("t5_blk_ready", a_blk_ready, 0);
    chk("t5_byte_valid", a_byte_valid, 0);
    chk("t5_byte_last", a_byte_last, 0);
    chk("t5_busy", a_busy, 0);
    chk("t5_byte_data", a_byte_data, 0);
    tick();
    chk("t5_idle_valid", a_byte_valid, 0);
    req_wait();
    collect(0);
    check_a("t5");

    // 6: request dropped in the second settle cycle.
    blk_valid = 1'b1;
    tick();
    tick();
    blk_valid = 1'b0;
    chk("t6_busy_settle", a_busy, 1);
    chk("t6_blk_ready", a_blk_ready, 0);
    tick();
    chk("t6_busy", a_busy, 0);
    chk("t6_byte_valid", a_byte_valid, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t6_no_valid", a_byte_valid, 0);
      chk("t6_no_ready", a_blk_ready, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
